axis_to_axi4_burst_writer: RTL and testbench
============================================

// Module: axis_to_axi4_burst_writer
// PURPOSE
//  Upstream stage of the 32->64 bit AXI4 width converter. Takes a 32-bit AXI4-Stream and issues
//  fixed-length INCR write bursts to consecutive addresses on a 32-bit AXI4 master port. That port
//  connects directly to the converter's 32-bit slave side. Write path only; the block never
//  drives the read channels.
// PARAMETERS
//  C_M_AXI_BURST_LEN   256  beats per burst; power of 2 in the range 2..256
//  C_M_AXI_ID_WIDTH    1    AWID/BID width; AWID is driven as 0
//  C_M_AXI_ADDR_WIDTH  32   address width
// PORTS
//  M_AXI_ACLK      in   1    clock; drives every register in the block
//  M_AXI_ARESETN   in   1    asynchronous, active-low reset
//  start           in   1    1-cycle pulse: latch base_addr and burst_count, begin the job
//  base_addr       in   AW   job start address; must be aligned to BURST_LEN*4 bytes
//  burst_count     in   16   number of bursts in the job
//  busy            out  1    job in progress
//  done            out  1    1-cycle pulse when the job completes
//  error           out  1    sticky: at least one BRESP!=0 in this job; cleared by start
//  debug_write     out  32   debug word (see CONFIGURATION)
//  S_AXIS_TDATA    in   32   stream data
//  S_AXIS_TVALID / S_AXIS_TREADY  in/out  1  stream handshake
//  S_AXIS_TLAST    in   1    end of stream packet
//  M_AXI_AWID / AWADDR / AWLEN  out  ID/AW/8  0 / current burst address / BURST_LEN-1
//  M_AXI_AWSIZE / AWBURST  out  3/2  constants 3'd2 / 2'b01 (INCR)
//  M_AXI_AWLOCK / AWCACHE / AWPROT / AWQOS  out  1/4/3/4  constants 0 / 4'b0011 / 0 / 0
//  M_AXI_AWVALID / M_AXI_AWREADY  out/in  1  AW handshake
//  M_AXI_WDATA / M_AXI_WSTRB  out  32/4  write data / byte strobes
//  M_AXI_WLAST / M_AXI_WVALID / M_AXI_WREADY  out/out/in  1  W channel
//  M_AXI_BID / M_AXI_BRESP  in  ID/2  write response; BID is ignored
//  M_AXI_BVALID / M_AXI_BREADY  in/out  1  B handshake
// BEHAVIOUR
//  Reset: busy, done, error, every VALID/READY output, the beat counter and the address register
//   clear to 0 immediately on reset assertion. State returns to IDLE. Reset mid-burst simply
//   abandons the burst.
//  FSM: IDLE -> AW -> W -> B -> (AW | DONE) -> IDLE.
//  IDLE: on start, latch address and count, clear error, set busy. start is ignored while busy.
//   burst_count=0: go to DONE with no AXI traffic; done pulses 1 cycle after start.
//  AW: hold AWVALID=1 with stable AWADDR until AWREADY. No W beats are issued before the AW
//   handshake.
//  W, stream path: WDATA=TDATA, WVALID=TVALID, TREADY=WREADY, WSTRB=4'hF. The path is
//   combinational, with zero added latency. A beat transfers when WVALID&WREADY; beat counter 0..LEN-1.
//  WLAST=1 exactly on beat LEN-1.
//  Early TLAST (accepted on a beat before LEN-1): the remaining beats become padding. Padding
//   beats drive WVALID=1, WDATA=0, WSTRB=0, TREADY=0. After that burst's B, go to DONE and skip
//   any remaining bursts. TLAST on beat LEN-1 also ends the job after B.
//  B: BREADY=1 only in B. On BVALID, if BRESP!=0 set error. Then AWADDR+=LEN*4 (wraps modulo
//   2^AW) and count-=1; count now 0 -> DONE, otherwise -> AW.
//  DONE: done=1 for one cycle, busy falls in the same cycle; next state IDLE.
//  TREADY=0 outside the W state, so the stream stalls between bursts and after the job ends.
//  Only one burst is outstanding at a time.
// CONFIGURATION
//  STREAMIF_BURST_WRITER_DEBUG_EN defined:
//   debug_write = {count[15:0], beat[7:0], 2'b0, error, AWVALID, WVALID, state[2:0]}.
//  Not defined: debug_write is 32'h0 and the related logic is not built.
// STRUCTURE
//  Package streamif_pkg: state encoding (IDLE=0, AW=1, W=2, B=3, DONE=4); AXI constants BURST_INCR,
//   SIZE_4B, CACHE_DEFAULT, RESP_OKAY.
//  Single module with no sub-modules. The stream path is a direct pass-through, so no FIFO is used.
// TESTING
//  1 base=0x1000_0000, count=2, words 0..511 with TLAST@511 -> AW at 0x1000_0000 and
//    0x1000_0400, WLAST on beats 255 and 511, data in order, done pulse, error=0.
//  2 Random AWREADY/WREADY/TVALID/BVALID stalls on test 1 -> identical beat sequence, no
//    loss/duplication, AWVALID/WVALID stable while stalled.
//  3 count=1, TLAST on word 99 -> beats 100..255 have WSTRB=0 WDATA=0, WLAST@255, done after B,
//    TREADY stays 0 afterwards.
//  4 count=3, TLAST on word 255 -> only one AW issued, done after the first B.
//  5 count=2, BRESP=2'b10 on burst 0 -> burst 1 still issued, error=1 at done; next start
//    clears error.
//  6 count=0 -> done 1 cycle after start, AWVALID never set; reset asserted in W -> outputs 0
//    immediately, and a new job then completes correctly.

Source files
------------

// File: rtl/streamif_pkg.sv
// Shared types and AXI constants for the stream-to-AXI4 burst writer.
// State encoding is fixed so it can be read directly from the debug word.
package streamif_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [2:0] SIZE_4B       = 3'd2;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] RESP_OKAY     = 2'b00;

endpackage

// File: rtl/axis_to_axi4_burst_writer.sv
// 32-bit AXI4-Stream to fixed-length AXI4 INCR write bursts, one burst in flight.
// Optional debug word: define STREAMIF_BURST_WRITER_DEBUG_EN.
module axis_to_axi4_burst_writer
  import streamif_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN  = 256,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]                   burst_count,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [31:0]                   debug_write,
  input  logic [31:0]                   S_AXIS_TDATA,
  input  logic                          S_AXIS_TVALID,
  output logic                          S_AXIS_TREADY,
  input  logic                          S_AXIS_TLAST,
  output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic [2:0]                    M_AXI_AWSIZE,
  output logic [1:0]                    M_AXI_AWBURST,
  output logic                          M_AXI_AWLOCK,
  output logic [3:0]                    M_AXI_AWCACHE,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic [3:0]                    M_AXI_AWQOS,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [31:0]                   M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_BID,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam logic [7:0] LAST_BEAT =
    8'(C_M_AXI_BURST_LEN - 1);
  localparam logic [AW-1:0] ADDR_STEP =
    AW'(C_M_AXI_BURST_LEN * 4);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     count_q, count_d;
  logic [7:0]      beat_q, beat_d;
  logic            error_q, error_d;
  logic            pad_q, pad_d;
  logic            stop_q, stop_d;

  logic            awvalid;
  logic            wvalid;
  logic            tready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            bready;
  logic            done_w;
  logic            last_beat;

  // BID carries no information for a single-ID master.
  logic unused_bid;
  assign unused_bid = ^M_AXI_BID;

  assign last_beat = (beat_q == LAST_BEAT);

  // State and job registers; reset abandons any burst in flight.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
      error_q <= 1'b0;
      pad_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      error_q <= error_d;
      pad_q   <= pad_d;
      stop_q  <= stop_d;
    end
  end

  // Next-state and channel control; the W path is a pure pass-through.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    beat_d  = beat_q;
    error_d = error_q;
    pad_d   = pad_q;
    stop_d  = stop_q;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    tready  = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    bready  = 1'b0;
    done_w  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          count_d = burst_count;
          error_d = 1'b0;
          beat_d  = '0;
          pad_d   = 1'b0;
          stop_d  = 1'b0;
          state_d = (burst_count == 16'd0)
                    ? S_DONE : S_AW;
        end
      end

      S_AW: begin
        awvalid = 1'b1;
        if (M_AXI_AWREADY) begin
          state_d = S_W;
        end
      end

      S_W: begin
        if (pad_q) begin
          wvalid = 1'b1;
        end else begin
          wvalid = S_AXIS_TVALID;
          tready = M_AXI_WREADY;
          wdata  = S_AXIS_TDATA;
          wstrb  = 4'hF;
        end
        if (wvalid && M_AXI_WREADY) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = S_B;
          end else begin
            beat_d = beat_q + 8'd1;
          end
          if (!pad_q && S_AXIS_TLAST) begin
            stop_d = 1'b1;
            if (!last_beat) begin
              pad_d = 1'b1;
            end
          end
        end
      end

      S_B: begin
        bready = 1'b1;
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != RESP_OKAY) begin
            error_d = 1'b1;
          end
          addr_d  = addr_q + ADDR_STEP;
          count_d = count_q - 16'd1;
          pad_d   = 1'b0;
          state_d = (count_q == 16'd1 || stop_q)
                    ? S_DONE : S_AW;
        end
      end

      S_DONE: begin
        done_w  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy  = (state_q == S_AW) ||
                 (state_q == S_W)  ||
                 (state_q == S_B);
  assign done  = done_w;
  assign error = error_q;

  assign S_AXIS_TREADY = tready;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = LAST_BEAT;
  assign M_AXI_AWSIZE  = SIZE_4B;
  assign M_AXI_AWBURST = BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = CACHE_DEFAULT;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWVALID = awvalid;

  assign M_AXI_WDATA  = wdata;
  assign M_AXI_WSTRB  = wstrb;
  assign M_AXI_WLAST  = (state_q == S_W) && last_beat;
  assign M_AXI_WVALID = wvalid;

  assign M_AXI_BREADY = bready;

`ifdef STREAMIF_BURST_WRITER_DEBUG_EN
  assign debug_write = {count_q, beat_q, 2'b00,
                        error_q, awvalid, wvalid,
                        state_q};
`else
  assign debug_write = 32'h0;
`endif

endmodule

// File: tb/tb_axis_to_axi4_burst_writer.sv
// Directed bench for the stream-to-AXI4 burst writer.
// Acts as stream source and AXI slave; checks every handshake.
module tb_axis_to_axi4_burst_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] burst_count;
  logic        busy, done, error;
  logic [31:0] debug_write;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axis_to_axi4_burst_writer dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .burst_count   (burst_count),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .debug_write   (debug_write),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXI_AWID    (awid),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWLEN   (awlen),
    .M_AXI_AWSIZE  (awsize),
    .M_AXI_AWBURST (awburst),
    .M_AXI_AWLOCK  (awlock),
    .M_AXI_AWCACHE (awcache),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWQOS   (awqos),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WLAST   (wlast),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BID     (bid),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    start    = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    bresp    = 2'b00;
    bid      = '0;
  endtask

  function automatic bit rnd(input bit stall);
    if (!stall) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // One job: stream words {tag, index}; TLAST on word tl_idx.
  // bad_b: burst index answered with SLVERR (-1 none).
  // abort_at: stop driving after that many W beats (-1 never).
  task automatic run_job(input logic [31:0] base,
                         input int cnt,
                         input int tl_idx,
                         input bit stall,
                         input int bad_b,
                         input int abort_at,
                         input logic [7:0] tag);
    int cyc, k, aw_n, wb, b_n, done_n, done_cyc;
    int exp_b, exp_w;
    bit fin, aborted, bpend, bv, tv_hold;
    bit pawv, pawr, pwv, pwr, pwlast;
    logic [31:0] paddr, pwdata;
    logic [3:0] pwstrb;
    logic exp_err;
    cyc = 0; k = 0; aw_n = 0; wb = 0; b_n = 0;
    done_n = 0; done_cyc = -1;
    fin = 0; aborted = 0; bpend = 0; bv = 0;
    tv_hold = 0; pawv = 0; pawr = 0; pwv = 0;
    pwr = 0; pwlast = 0; paddr = '0; pwdata = '0;
    pwstrb = '0;
    exp_b = (tl_idx / 256 + 1 < cnt)
            ? tl_idx / 256 + 1 : cnt;
    exp_w = (tl_idx + 1 < exp_b * 256)
            ? tl_idx + 1 : exp_b * 256;
    exp_err = (bad_b >= 0) && (bad_b < exp_b);

    @(negedge clk);
    set_idle();
    start       = 1'b1;
    base_addr   = base;
    burst_count = cnt[15:0];

    while (!fin) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (!tv_hold) s_tvalid = rnd(stall);
      s_tdata = {tag, 24'(k)};
      s_tlast = (k == tl_idx);
      awready = rnd(stall);
      wready  = rnd(stall);
      if (bpend && !bv) bv = rnd(stall);
      bvalid = bv;
      bresp  = (b_n == bad_b) ? 2'b10 : 2'b00;
      #1;
      if (cyc == 1) begin
        chk("busy_after_start", busy, cnt != 0);
        chk("error_cleared", error, 1'b0);
      end
      if (pawv && !pawr) begin
        chk("awvalid_stable", awvalid, 1'b1);
        chk("awaddr_stable", awaddr, paddr);
      end
      if (pwv && !pwr) begin
        chk("wvalid_stable", wvalid, 1'b1);
        chk("wdata_stable", wdata, pwdata);
        chk("wstrb_stable", wstrb, pwstrb);
        chk("wlast_stable", wlast, pwlast);
      end
      if (wvalid && wready) begin
        chk("w_after_aw", aw_n, b_n + 1);
        if (wb < exp_w) begin
          chk("wdata", wdata, {tag, 24'(wb)});
          chk("wstrb", wstrb, 4'hF);
          chk("tready_data", s_tready, 1'b1);
        end else begin
          chk("pad_wdata", wdata, 32'h0);
          chk("pad_wstrb", wstrb, 4'h0);
          chk("pad_tready", s_tready, 1'b0);
        end
        chk("wlast", wlast, (wb % 256) == 255);
        if (wlast) bpend = 1;
        wb++;
      end
      if (awvalid && awready) begin
        chk("awaddr", awaddr,
            base + 32'(aw_n) * 32'd1024);
        chk("aw_one_outstanding", aw_n, b_n);
        chk("aw_consts",
            32'({awlen, awsize, awburst, awcache,
                 awlock, awprot, awqos, awid}),
            32'({8'hFF, 3'd2, 2'b01, 4'b0011,
                 1'b0, 3'd0, 4'd0, 1'b0}));
        aw_n++;
      end
      if (s_tvalid && s_tready) k++;
      if (bvalid && bready) begin
        b_n++;
        bpend = 0;
        bv = 0;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
        chk("busy_at_done", busy, 1'b0);
        fin = 1;
      end
      tv_hold = s_tvalid && !s_tready;
      pawv = awvalid; pawr = awready;
      paddr = awaddr;
      pwv = wvalid; pwr = wready;
      pwdata = wdata; pwstrb = wstrb;
      pwlast = wlast;
      if (abort_at >= 0 && wb >= abort_at) begin
        aborted = 1;
        fin = 1;
      end
      if (cyc > 20000) begin
        chk("timeout", 32'd0, 32'd1);
        fin = 1;
      end
    end

    if (!aborted) begin
      chk("aw_count", aw_n, exp_b);
      chk("b_count", b_n, exp_b);
      chk("w_beats", wb, exp_b * 256);
      chk("words_taken", k, exp_w);
      chk("done_pulses", done_n, 1);
      chk("error_at_done", error, exp_err);
      if (cnt == 0) chk("done_cycle", done_cyc, 1);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        s_tvalid = 1'b1;
        awready  = 1'b1;
        wready   = 1'b1;
        bvalid   = 1'b0;
        #1;
        if (i == 0) chk("done_width", done, 1'b0);
        chk("post_tready", s_tready, 1'b0);
        chk("post_awvalid", awvalid, 1'b0);
        chk("post_wvalid", wvalid, 1'b0);
        chk("post_busy", busy, 1'b0);
        chk("error_sticky", error, exp_err);
      end
    end
  endtask

  initial begin
    set_idle();
    base_addr   = '0;
    burst_count = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_debug", debug_write, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(32'h1000_0000, 2, 511, 0, -1, -1, 8'h01);
    run_job(32'h1000_0000, 2, 511, 1, -1, -1, 8'h02);
    run_job(32'h2000_0000, 1, 99, 1, -1, -1, 8'h03);
    run_job(32'h3000_0400, 3, 255, 0, -1, -1, 8'h04);
    run_job(32'hFFFF_FC00, 2, 100000, 1, 0, -1, 8'h05);
    run_job(32'h4000_0000, 1, 100000, 0, -1, -1, 8'h06);
    run_job(32'h5000_0000, 1, 100000, 0, 0, -1, 8'h07);

    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("idle_rst_error", error, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(32'h6000_0000, 0, 100000, 0, -1, -1, 8'h08);

    run_job(32'h7000_0000, 2, 100000, 0, -1, 50, 8'h09);
    s_tvalid = 1'b1;
    wready   = 1'b1;
    #2;
    chk("pre_rst_wvalid", wvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_tready", s_tready, 1'b0);
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_bready", bready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;

    run_job(32'h8000_0000, 2, 300, 1, -1, -1, 8'h0A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
